// File: rtl/skl_adder_pkg.sv
// skl_adder_pkg: shared types and helpers for the pipelined Sklansky adder.
//   pg_t       - (generate, propagate) pair for one bit or one bit group
//   skl_levels - number of Sklansky prefix levels for a given operand width
package skl_adder_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  function automatic int unsigned skl_levels(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/skl_pg_cell.sv
// skl_pg_cell: prefix combine operator for one Sklansky node.
//   hi - (G,P) of the more significant group
//   lo - (G,P) of the less significant, adjacent group
//   o  - (G,P) of the merged group: (Gh | Ph&Gl, Ph&Pl)
module skl_pg_cell
  import skl_adder_pkg::*;
(
  input  pg_t hi,
  input  pg_t lo,
  output pg_t o
);

  always_comb begin
    o.g = hi.g | (hi.p & lo.g);
    o.p = hi.p & lo.p;
  end

endmodule

// File: rtl/sklansky_adder_pipe.sv
// sklansky_adder_pipe: {cout,sum} = a + b + cin using a Sklansky parallel-prefix
// carry tree with one register stage per prefix level (LEVELS+1 stages total).
//   clk, rst_n           - clock, synchronous active-low reset
//   in_valid / in_ready  - operand handshake (in_ready = pipeline advance)
//   a, b, cin            - operands and carry-in
//   sum, cout            - registered result and carry out of bit WIDTH-1
//   out_valid / out_ready- result handshake
//   ovf                  - signed-overflow flag, only when SKL_ADDER_OVF_EN is defined
// WIDTH must be a power of two, 4..64. LEVELS is derived; do not override it.
module sklansky_adder_pipe
  import skl_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned LEVELS = skl_levels(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SKL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // grp_q[k]: group (G,P) after prefix level k (k=0 is bitwise, cin merged).
  // The last stage registers the finished sum directly, so it has no grp_q slot.
  pg_t  [WIDTH-1:0] grp_q [LEVELS];
  pg_t  [WIDTH-1:0] lvl   [1:LEVELS];
  pg_t  [WIDTH-1:0] grp_d;
  logic [WIDTH-1:0] p0_q  [LEVELS];
  logic [LEVELS-1:0] cin_q;
  logic [LEVELS:0]  vld_q;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_d;
  logic             adv;
`ifdef SKL_ADDER_OVF_EN
  logic [LEVELS-1:0] sa_q;
`endif

  assign out_valid = vld_q[LEVELS];
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;

  // Bit 0 absorbs the carry-in, so its group never propagates further.
  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      grp_d[i].g = a[i] & b[i];
      grp_d[i].p = a[i] ^ b[i];
    end
    grp_d[0].g = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
    grp_d[0].p = 1'b0;
  end

  // Level k: bits in the upper half of each 2^k block combine with the top
  // bit of the lower half; the rest pass through unchanged.
  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (((i >> (k - 1)) & 1) == 1) begin : g_cell
        skl_pg_cell u_cell (
          .hi (grp_q[k-1][i]),
          .lo (grp_q[k-1][((i >> k) << k) + (1 << (k - 1)) - 1]),
          .o  (lvl[k][i])
        );
      end else begin : g_pass
        assign lvl[k][i] = grp_q[k-1][i];
      end
    end
  end

  // After the final level, G[i] is the carry out of bit i.
  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      carry[i] = lvl[LEVELS][i].g;
    end
    sum_d = p0_q[LEVELS-1] ^ {carry[WIDTH-2:0], cin_q[LEVELS-1]};
  end

  // Intermediate data stages need no reset: their valid bits gate them.
  always_ff @(posedge clk) begin
    if (adv) begin
      grp_q[0] <= grp_d;
      p0_q[0]  <= a ^ b;
      cin_q    <= {cin_q[LEVELS-2:0], cin};
`ifdef SKL_ADDER_OVF_EN
      sa_q     <= {sa_q[LEVELS-2:0], a[WIDTH-1]};
`endif
      for (int unsigned k = 1; k < LEVELS; k++) begin
        grp_q[k] <= lvl[k];
        p0_q[k]  <= p0_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SKL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (adv) begin
      vld_q <= {vld_q[LEVELS-1:0], in_valid};
      sum   <= sum_d;
      cout  <= carry[WIDTH-1];
`ifdef SKL_ADDER_OVF_EN
      // Equal operand signs (P0 msb clear) but a result sign differing from a.
      ovf   <= ~p0_q[LEVELS-1][WIDTH-1] & (sum_d[WIDTH-1] ^ sa_q[LEVELS-1]);
`endif
    end
  end

endmodule

// File: tb/tb_sklansky_adder_pipe.sv
// tb_sklansky_adder_pipe: directed bench for sklansky_adder_pipe at WIDTH 4, 16
// and 64, with per-instance in-order scoreboards on the output handshake.
// Honours SKL_ADDER_OVF_EN when defined.
module tb_sklansky_adder_pipe;

`ifdef SKL_ADDER_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready, cin;
  logic [63:0] a64, b64;

  logic        in_ready4, out_valid4, cout4, ovf4;
  logic [3:0]  sum4;
  logic        in_ready16, out_valid16, cout16, ovf16;
  logic [15:0] sum16;
  logic        in_ready64, out_valid64, cout64, ovf64;
  logic [63:0] sum64;

  int unsigned n_checks = 0, n_errors = 0;
  int unsigned n_acc4 = 0, n_acc16 = 0, n_acc64 = 0;
  int unsigned n_pop4 = 0, n_pop16 = 0, n_pop64 = 0;
  logic [65:0] q4[$], q16[$], q64[$];

  int unsigned lat4, lat16, lat64;
  logic [5:0]  res4;
  logic [17:0] res16;
  logic [65:0] res64;
  int unsigned run4, run16, run64, best4, best16, best64;
  int unsigned s4, s16, s64, seen, k;
  logic [7:0]  pat, obs;
  logic        started;

  always #5 clk = ~clk;

  sklansky_adder_pipe #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a64[3:0]), .b(b64[3:0]), .cin(cin), .sum(sum4), .cout(cout4),
    .out_valid(out_valid4), .out_ready(out_ready)
`ifdef SKL_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );

  sklansky_adder_pipe #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .a(a64[15:0]), .b(b64[15:0]), .cin(cin), .sum(sum16), .cout(cout16),
    .out_valid(out_valid16), .out_ready(out_ready)
`ifdef SKL_ADDER_OVF_EN
    , .ovf(ovf16)
`endif
  );

  sklansky_adder_pipe #(.WIDTH(64)) u_w64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .a(a64), .b(b64), .cin(cin), .sum(sum64), .cout(cout64),
    .out_valid(out_valid64), .out_ready(out_ready)
`ifdef SKL_ADDER_OVF_EN
    , .ovf(ovf64)
`endif
  );

`ifndef SKL_ADDER_OVF_EN
  assign ovf4  = 1'b0;
  assign ovf16 = 1'b0;
  assign ovf64 = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer addition on the low w bits, packed {ovf,cout,sum}.
  function automatic logic [65:0] ref_add(input int unsigned w, input logic [63:0] av,
                                          input logic [63:0] bv, input logic cv);
    logic [64:0] r;
    logic [63:0] m;
    logic        ov;
    m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    r  = {1'b0, av & m} + {1'b0, bv & m} + {64'd0, cv};
    ov = OVF_ON && (av[w-1] == bv[w-1]) && (r[w-1] != av[w-1]);
    return {ov, r[w], r[63:0] & m};
  endfunction

  // Scoreboards: inputs/outputs are stable at negedge for the coming posedge.
  always @(negedge clk) begin
    if (!rst_n) q4.delete();
    else begin
      if (out_valid4 && out_ready) begin
        if (q4.size() == 0) check_eq("dup4", out_valid4, 0);
        else begin check_eq("res4", {ovf4, cout4, 60'h0, sum4}, q4.pop_front()); n_pop4++; end
      end
      if (in_valid && in_ready4) begin q4.push_back(ref_add(4, a64, b64, cin)); n_acc4++; end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) q16.delete();
    else begin
      if (out_valid16 && out_ready) begin
        if (q16.size() == 0) check_eq("dup16", out_valid16, 0);
        else begin check_eq("res16", {ovf16, cout16, 48'h0, sum16}, q16.pop_front()); n_pop16++; end
      end
      if (in_valid && in_ready16) begin q16.push_back(ref_add(16, a64, b64, cin)); n_acc16++; end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) q64.delete();
    else begin
      if (out_valid64 && out_ready) begin
        if (q64.size() == 0) check_eq("dup64", out_valid64, 0);
        else begin check_eq("res64", {ovf64, cout64, sum64}, q64.pop_front()); n_pop64++; end
      end
      if (in_valid && in_ready64) begin q64.push_back(ref_add(64, a64, b64, cin)); n_acc64++; end
    end
  end

  // One isolated transaction; records first-valid cycle and result per width.
  task automatic one_shot(input logic [63:0] av, input logic [63:0] bv, input logic cv);
    a64 = av; b64 = bv; cin = cv; in_valid = 1'b1;
    lat4 = 0; lat16 = 0; lat64 = 0;
    res4 = '0; res16 = '0; res64 = '0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      if (out_valid4 && lat4 == 0) begin lat4 = n; res4 = {ovf4, cout4, sum4}; end
      if (out_valid16 && lat16 == 0) begin lat16 = n; res16 = {ovf16, cout16, sum16}; end
      if (out_valid64 && lat64 == 0) begin lat64 = n; res64 = {ovf64, cout64, sum64}; end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0; a64 = '0; b64 = '0;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", in_ready16, 1);
    check_eq("rst_out_valid", {out_valid4, out_valid16, out_valid64}, 3'b000);
    check_eq("rst_sum_cout", {cout16, sum16}, 17'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;

    one_shot(64'hFFFF, 64'h0001, 1'b0);
    check_eq("lat4", lat4, 3);
    check_eq("lat16", lat16, 5);
    check_eq("lat64", lat64, 7);
    check_eq("ffff_p1_w16", res16, {1'b0, 1'b1, 16'h0000});
    check_eq("ffff_p1_w64", res64, {1'b0, 1'b0, 64'h10000});

    one_shot(64'h7FFF, 64'h0001, 1'b0);
    check_eq("7fff_p1_w16", res16, {OVF_ON, 1'b0, 16'h8000});
    check_eq("f_p1_w4", res4, {1'b0, 1'b1, 4'h0});

    one_shot('1, 64'h0, 1'b1);
    check_eq("ones_cin_w4", res4, {1'b0, 1'b1, 4'h0});
    check_eq("ones_cin_w16", res16, {1'b0, 1'b1, 16'h0000});
    check_eq("ones_cin_w64", res64, {1'b0, 1'b1, 64'h0});

    one_shot(64'h8000, 64'h8000, 1'b0);
    check_eq("neg_ovf_w16", res16, {OVF_ON, 1'b1, 16'h0000});

    // Back-to-back stream of 8.
    s4 = n_pop4; s16 = n_pop16; s64 = n_pop64;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          a64 = {$urandom(), $urandom()}; b64 = {$urandom(), $urandom()};
          cin = 1'($urandom_range(1, 0)); in_valid = 1'b1;
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        run4 = 0; run16 = 0; run64 = 0; best4 = 0; best16 = 0; best64 = 0;
        for (int n = 0; n < 30; n++) begin
          @(negedge clk);
          run4  = out_valid4  ? run4 + 1  : 0; if (run4 > best4) best4 = run4;
          run16 = out_valid16 ? run16 + 1 : 0; if (run16 > best16) best16 = run16;
          run64 = out_valid64 ? run64 + 1 : 0; if (run64 > best64) best64 = run64;
        end
      end
    join
    @(posedge clk); #1;
    check_eq("stream_run4", best4, 8);
    check_eq("stream_run16", best16, 8);
    check_eq("stream_run64", best64, 8);
    check_eq("stream_cnt16", n_pop16 - s16, 8);
    check_eq("stream_cnt4_64", {n_pop4 - s4, n_pop64 - s64}, {32'd8, 32'd8});

    // Bubbles must survive the pipe unchanged.
    pat = 8'b1011_0101;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          a64 = {$urandom(), $urandom()}; b64 = {$urandom(), $urandom()};
          cin = 1'($urandom_range(1, 0)); in_valid = pat[i];
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        started = 1'b0; k = 0; obs = '0;
        for (int n = 0; n < 30; n++) begin
          @(negedge clk);
          if (!started && out_valid16) started = 1'b1;
          if (started && k < 8) begin obs[k] = out_valid16; k++; end
        end
      end
    join
    @(posedge clk); #1;
    check_eq("bubble_pattern16", obs, pat);

    // Fill with out_ready low, hold 6 cycles, then drain.
    s4 = n_acc4; s16 = n_acc16; s64 = n_acc64;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a64 = {$urandom(), $urandom()}; b64 = {$urandom(), $urandom()};
      cin = 1'($urandom_range(1, 0)); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    check_eq("stall_acc4", n_acc4 - s4, 3);
    check_eq("stall_acc16", n_acc16 - s16, 5);
    check_eq("stall_acc64", n_acc64 - s64, 7);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("stall_ready", {in_ready4, in_ready16, in_ready64}, 3'b000);
      check_eq("stall_hold16", {ovf16, cout16, 48'h0, sum16}, q16[0]);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    s4 = n_pop4; s16 = n_pop16; s64 = n_pop64;
    out_ready = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check_eq("drain_cnt16", n_pop16 - s16, 5);
    check_eq("drain_cnt4_64", {n_pop4 - s4, n_pop64 - s64}, {32'd3, 32'd7});

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      a64 = {$urandom(), $urandom()}; b64 = {$urandom(), $urandom()};
      cin = 1'($urandom_range(1, 0)); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    rst_n = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("flush_valid", {out_valid4, out_valid16, out_valid64}, 3'b000);
    check_eq("flush_sum_cout", {cout16, sum16}, 17'h0);
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (out_valid4 || out_valid16 || out_valid64) seen++;
    end
    check_eq("flush_no_emit", seen, 0);
    @(posedge clk); #1;

    one_shot(64'h1234, 64'h4321, 1'b1);
    check_eq("post_rst_lat16", lat16, 5);
    check_eq("post_rst_w16", res16, {1'b0, 1'b0, 16'h5556});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
